fifo_wr_packer: RTL

FIFO_WR_PACKER -- requirements
Module: fifo_wr_packer

---
 rtl/fifo_if_pkg.sv | 25 ++
 rtl/fifo_wr_packer.sv | 103 ++++++++++
 2 files changed

// File: rtl/fifo_if_pkg.sv
// Shared sizing helpers for the FIFO write packer.
// Holds the lane ratio, lane-counter width and the width legality check.
package fifo_if_pkg;

    localparam int DEF_WIDTH_IN  = 32;
    localparam int DEF_WIDTH_OUT = 256;

    // Number of input lanes in one packed FIFO word.
    function automatic int calc_ratio(input int win, input int wout);
        return wout / win;
    endfunction

    // Lane counter width; never narrower than one bit.
    function automatic int lane_bits(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

    // Output width must be a whole multiple (at least 2x) of the input width.
    function automatic bit width_ok(input int win, input int wout);
        if (win <= 0) return 1'b0;
        if ((wout % win) != 0) return 1'b0;
        return (wout / win) >= 2;
    endfunction

endpackage

// File: rtl/fifo_wr_packer.sv
// Packs narrow input words into wide FIFO write words (lane 0 first).
// Ports: clk, rst_n (sync, active-low), s_data/s_valid/s_last/s_ready input
//   stream, fifo_wrdata/fifo_wren/fifo_full write side, wr_count write tally.
module fifo_wr_packer
    import fifo_if_pkg::*;
#(
    parameter int WIDTH_IN  = DEF_WIDTH_IN,
    parameter int WIDTH_OUT = DEF_WIDTH_OUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH_IN-1:0]  s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [WIDTH_OUT-1:0] fifo_wrdata,
    output logic                 fifo_wren,
    input  logic                 fifo_full,
    output logic [31:0]          wr_count
);

    localparam int RATIO = calc_ratio(WIDTH_IN, WIDTH_OUT);
    localparam int LW    = lane_bits(RATIO);
    localparam logic [LW-1:0] LANE_MAX = LW'(RATIO - 1);

    generate
        if (!width_ok(WIDTH_IN, WIDTH_OUT)) begin : g_bad_width
            $error("fifo_wr_packer: WIDTH_OUT must be a multiple >= 2 of WIDTH_IN");
        end
    endgenerate

    logic [LW-1:0]        lane;
    logic [WIDTH_OUT-1:0] pack_data;
    logic [WIDTH_OUT-1:0] pack_nxt;
    logic [WIDTH_OUT-1:0] out_data;
    logic                 pack_full;
    logic                 out_vld;
    logic                 accept;
    logic                 complete;
    logic                 wr_fire;
    logic                 out_free;
    int                   lane_base;

    // s_ready depends on registered state only.
    assign s_ready  = !pack_full;
    assign accept   = s_valid && !pack_full;
    assign complete = accept && (s_last || (lane == LANE_MAX));
    assign wr_fire  = out_vld && !fifo_full;
    assign out_free = !out_vld || wr_fire;

    assign fifo_wren   = wr_fire;
    assign fifo_wrdata = out_data;

    // Lane 0 starts from zero, so short (s_last) words have clean upper lanes
    // and a stale held word never leaks into the next one.
    always_comb begin
        lane_base = int'(lane) * WIDTH_IN;
        pack_nxt  = (lane == '0) ? '0 : pack_data;
        pack_nxt[lane_base +: WIDTH_IN] = s_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane      <= '0;
            pack_data <= '0;
            out_data  <= '0;
            out_vld   <= 1'b0;
            pack_full <= 1'b0;
            wr_count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_count <= wr_count + 32'd1;
            end
            if (accept) begin
                lane <= complete ? '0 : lane + LW'(1);
            end
            if (pack_full) begin
                // Held word moves as soon as the output slot frees.
                if (out_free) begin
                    out_data  <= pack_data;
                    out_vld   <= 1'b1;
                    pack_full <= 1'b0;
                end
            end else if (complete) begin
                if (out_free) begin
                    out_data <= pack_nxt;
                    out_vld  <= 1'b1;
                end else begin
                    pack_data <= pack_nxt;
                    pack_full <= 1'b1;
                end
            end else begin
                if (accept) begin
                    pack_data <= pack_nxt;
                end
                if (wr_fire) begin
                    out_vld <= 1'b0;
                end
            end
        end
    end

endmodule
